// File: rtl/bw_clk_gl_hz_seq.sv
// ---------------------------------------------------------------------------
// bw_clk_gl_hz_seq
// Sequenced enable generator for the column clock gaters of the horizontal
// clock spine. Columns are switched on (and later off) one at a time with a
// programmable stagger interval, which limits di/dt on the global grid.
//
// Ports:
//   clk       global clock, all flops on posedge
//   rst       asynchronous active-high reset
//   on_req    level request to ramp columns on (accepted only in OFF)
//   off_req   level request to ramp columns off (accepted in ON or RAMP_UP)
//   col_mask  columns taking part in ramp-up, latched when on_req is accepted
//   step_cyc  stagger interval in cycles, latched with col_mask, 0 acts as 1
//   col_en    per-column gater enables, registered, at most one bit per edge
//   busy      high while ramping up or down (registered)
//   on_ack    one-cycle pulse on entering ON
//   off_ack   one-cycle pulse on entering OFF after a ramp-down
// ---------------------------------------------------------------------------
module bw_clk_gl_hz_seq #(
  parameter int NCOL   = 4,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on_req,
  input  logic              off_req,
  input  logic [NCOL-1:0]   col_mask,
  input  logic [STEP_W-1:0] step_cyc,
  output logic [NCOL-1:0]   col_en,
  output logic              busy,
  output logic              on_ack,
  output logic              off_ack
);

  localparam int IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOL - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_RAMP_UP   = 2'b01,
    ST_ON        = 2'b10,
    ST_RAMP_DOWN = 2'b11
  } state_t;

  state_t              state_r, state_n;
  logic [IDX_W-1:0]    idx_r, idx_n;
  logic [STEP_W-1:0]   cnt_r, cnt_n;
  logic [STEP_W-1:0]   step_r, step_n;
  logic [NCOL-1:0]     mask_r, mask_n;
  logic [NCOL-1:0]     col_en_r, col_en_n;
  logic                busy_r, busy_n;
  logic                on_ack_r, on_ack_n;
  logic                off_ack_r, off_ack_n;

  // Next-state, counters and column enables of the ramp sequencer
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    cnt_n     = cnt_r;
    step_n    = step_r;
    mask_n    = mask_r;
    col_en_n  = col_en_r;
    on_ack_n  = 1'b0;
    off_ack_n = 1'b0;

    case (state_r)
      ST_OFF: begin
        // off_req is meaningless here, so on_req wins a simultaneous request
        if (on_req) begin
          mask_n  = col_mask;
          step_n  = (step_cyc == {STEP_W{1'b0}}) ? CNT_ONE : step_cyc;
          idx_n   = {IDX_W{1'b0}};
          cnt_n   = {STEP_W{1'b0}};
          state_n = ST_RAMP_UP;
        end else begin
          state_n = ST_OFF;
        end
      end

      ST_RAMP_UP: begin
        if (off_req) begin
          // Abort: already-enabled columns are cleared by the ramp-down walk
          idx_n   = LAST_IDX;
          cnt_n   = {STEP_W{1'b0}};
          state_n = ST_RAMP_DOWN;
        end else if (cnt_r != {STEP_W{1'b0}}) begin
          cnt_n = cnt_r - CNT_ONE;
        end else begin
          // A masked-off column is a one-cycle skip and leaves cnt at zero
          if (mask_r[idx_r]) begin
            col_en_n[idx_r] = 1'b1;
            cnt_n           = step_r - CNT_ONE;
          end else begin
            cnt_n = {STEP_W{1'b0}};
          end
          if (idx_r == LAST_IDX) begin
            state_n  = ST_ON;
            on_ack_n = 1'b1;
          end else begin
            idx_n = idx_r + IDX_ONE;
          end
        end
      end

      ST_ON: begin
        if (off_req) begin
          idx_n   = LAST_IDX;
          cnt_n   = {STEP_W{1'b0}};
          state_n = ST_RAMP_DOWN;
        end else begin
          state_n = ST_ON;
        end
      end

      ST_RAMP_DOWN: begin
        // Ramp-down always runs to completion; on_req waits for OFF
        if (cnt_r != {STEP_W{1'b0}}) begin
          cnt_n = cnt_r - CNT_ONE;
        end else begin
          if (col_en_r[idx_r]) begin
            col_en_n[idx_r] = 1'b0;
            cnt_n           = step_r - CNT_ONE;
          end else begin
            cnt_n = {STEP_W{1'b0}};
          end
          if (idx_r == {IDX_W{1'b0}}) begin
            state_n   = ST_OFF;
            off_ack_n = 1'b1;
          end else begin
            idx_n = idx_r - IDX_ONE;
          end
        end
      end

      default: begin
        state_n  = ST_OFF;
        col_en_n = {NCOL{1'b0}};
      end
    endcase

    busy_n = (state_n == ST_RAMP_UP) || (state_n == ST_RAMP_DOWN);
  end

  // State and output registers; reset drops every enable without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_OFF;
      idx_r     <= {IDX_W{1'b0}};
      cnt_r     <= {STEP_W{1'b0}};
      step_r    <= CNT_ONE;
      mask_r    <= {NCOL{1'b0}};
      col_en_r  <= {NCOL{1'b0}};
      busy_r    <= 1'b0;
      on_ack_r  <= 1'b0;
      off_ack_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      cnt_r     <= cnt_n;
      step_r    <= step_n;
      mask_r    <= mask_n;
      col_en_r  <= col_en_n;
      busy_r    <= busy_n;
      on_ack_r  <= on_ack_n;
      off_ack_r <= off_ack_n;
    end
  end

  assign col_en  = col_en_r;
  assign busy    = busy_r;
  assign on_ack  = on_ack_r;
  assign off_ack = off_ack_r;

endmodule

// File: tb/tb_bw_clk_gl_hz_seq.sv
// ---------------------------------------------------------------------------
// tb_bw_clk_gl_hz_seq
// Self-checking bench for bw_clk_gl_hz_seq (NCOL=4, STEP_W=4). Each queue
// entry holds the request levels to drive before an edge and the outputs
// expected just after it. Expected timelines are built from the stagger
// rules: a present column costs `step` cycles, a skipped one costs 1.
// ---------------------------------------------------------------------------
module tb_bw_clk_gl_hz_seq;

  logic       clk;
  logic       rst;
  logic       on_req;
  logic       off_req;
  logic [3:0] col_mask;
  logic [3:0] step_cyc;
  logic [3:0] col_en;
  logic       busy;
  logic       on_ack;
  logic       off_ack;

  bw_clk_gl_hz_seq #(.NCOL(4), .STEP_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .on_req   (on_req),
    .off_req  (off_req),
    .col_mask (col_mask),
    .step_cyc (step_cyc),
    .col_en   (col_en),
    .busy     (busy),
    .on_ack   (on_ack),
    .off_ack  (off_ack)
  );

  typedef struct {
    logic       on;
    logic       off;
    logic [3:0] col;
    logic       busy;
    logic       ona;
    logic       offa;
  } entry_t;

  entry_t     sb[$];
  logic [3:0] mcol;
  int         checks;
  int         errors;
  int         cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Ramp-down from the current model enables; e0 pushes the off_req edge
  task automatic gen_down(input int s, input bit e0);
    entry_t     e;
    logic [3:0] c;
    logic       was;
    c = mcol;
    if (e0) begin
      e = '{1'b0, 1'b1, c, 1'b1, 1'b0, 1'b0};
      sb.push_back(e);
    end
    for (int i = 3; i >= 0; i--) begin
      was  = c[i];
      c[i] = 1'b0;
      e = '{1'b0, 1'b0, c, (i != 0), 1'b0, (i == 0)};
      sb.push_back(e);
      if (was && i != 0) begin
        for (int k = 1; k < s; k++) begin
          e = '{1'b0, 1'b0, c, 1'b1, 1'b0, 1'b0};
          sb.push_back(e);
        end
      end
    end
    mcol = c;
  endtask

  // Ramp-up from OFF; abort_at>0 drives off_req at that edge instead
  task automatic gen_up(input logic [3:0] m, input logic [3:0] st, input int abort_at);
    entry_t     e;
    entry_t     tmp[$];
    logic [3:0] c;
    int         s;
    s = (st == 4'd0) ? 1 : int'(st);
    c = mcol;
    e = '{1'b1, 1'b0, c, 1'b1, 1'b0, 1'b0};
    tmp.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) c[i] = 1'b1;
      e = '{1'b0, 1'b0, c, (i != 3), (i == 3), 1'b0};
      tmp.push_back(e);
      if (m[i] && i != 3) begin
        for (int k = 1; k < s; k++) begin
          e = '{1'b0, 1'b0, c, 1'b1, 1'b0, 1'b0};
          tmp.push_back(e);
        end
      end
    end
    if (abort_at > 0) begin
      for (int j = 0; j < abort_at; j++) sb.push_back(tmp[j]);
      c = tmp[abort_at-1].col;
      e = '{1'b0, 1'b1, c, 1'b1, 1'b0, 1'b0};
      sb.push_back(e);
      mcol = c;
      gen_down(s, 1'b0);
    end else begin
      foreach (tmp[j]) sb.push_back(tmp[j]);
      mcol = c;
    end
  endtask

  // Drive queued entries (n<0: all) and compare just after each edge
  task automatic run(input int n);
    entry_t e;
    int     done;
    done = 0;
    while (sb.size() > 0 && (n < 0 || done < n)) begin
      e = sb.pop_front();
      on_req  = e.on;
      off_req = e.off;
      @(posedge clk);
      #1;
      cyc++;
      chk("col_en",  32'(col_en),  32'(e.col));
      chk("busy",    32'(busy),    32'(e.busy));
      chk("on_ack",  32'(on_ack),  32'(e.ona));
      chk("off_ack", 32'(off_ack), 32'(e.offa));
      on_req  = 1'b0;
      off_req = 1'b0;
      done++;
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_col_en",  32'(col_en),  32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_on_ack",  32'(on_ack),  32'd0);
    chk("rst_off_ack", 32'(off_ack), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    mcol = 4'd0;
    sb.delete();
  endtask

  initial begin
    entry_t e;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    mcol     = 4'd0;
    rst      = 1'b1;
    on_req   = 1'b0;
    off_req  = 1'b0;
    col_mask = 4'b1111;
    step_cyc = 4'd4;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // off_req alone is ignored in OFF
    e = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    run(-1);

    // Plan 1/2: full mask, step 4, up then down
    gen_up(4'b1111, 4'd4, 0);
    run(-1);
    step_cyc = 4'd2;
    col_mask = 4'b0000;
    gen_down(4, 1'b1);
    run(-1);

    // Plan 3: mask 1011 with idx2 skip
    col_mask = 4'b1011;
    step_cyc = 4'd4;
    gen_up(4'b1011, 4'd4, 0);
    run(-1);
    gen_down(4, 1'b1);
    run(-1);

    // Plan 4: step 0 behaves as 1; step change in ON has no effect
    col_mask = 4'b1111;
    step_cyc = 4'd0;
    gen_up(4'b1111, 4'd0, 0);
    run(-1);
    step_cyc = 4'd7;
    gen_down(1, 1'b1);
    run(-1);

    // All-zero mask: NCOL skips then on_ack with nothing enabled
    col_mask = 4'b0000;
    step_cyc = 4'd3;
    gen_up(4'b0000, 4'd3, 0);
    run(-1);
    gen_down(3, 1'b1);
    run(-1);

    // Plan 5: abort at E6 of the full-mask ramp
    col_mask = 4'b1111;
    step_cyc = 4'd4;
    gen_up(4'b1111, 4'd4, 6);
    run(-1);

    // Plan 6: async reset mid ramp with col_en=0111
    gen_up(4'b1111, 4'd4, 0);
    run(10);
    do_reset();

    // Both requests in OFF: on_req wins
    gen_up(4'b1111, 4'd4, 0);
    sb[0].off = 1'b1;
    run(3);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bw_clk_gl_hz_seq.md
Name: bw_clk_gl_hz_seq

Overview:
Parametrised successor to the fixed 4-column horizontal clock spine. It drives one enable per column clock gater from a sequenced state machine. Columns are switched on and off one at a time, with a programmable stagger interval between them, to limit di/dt on the global grid. It sits beside the horizontal spine, in the global clock domain it controls, and handshakes with the clock controller through level requests and one-cycle acknowledges.

Parameters:
NCOL, 4, number of column enables (>=1)
STEP_W, 4, width of stagger interval field
IDX_W, $clog2(NCOL) (min 1), column index width (derived, not overridden)

Ports:
clk  input  1  global clock, all flops on posedge
rst  input  1  asynchronous active-high reset
on_req  input  1  level request to ramp columns on
off_req  input  1  level request to ramp columns off
col_mask  input  NCOL  columns participating in ramp-up; latched on on_req acceptance
step_cyc  input  STEP_W  stagger interval in cycles; latched with col_mask; 0 treated as 1
col_en  output  NCOL  per-column gater enable, registered
busy  output  1  high in RAMP_UP / RAMP_DOWN
on_ack  output  1  one-cycle pulse on entering ON
off_ack  output  1  one-cycle pulse on entering OFF after ramp-down

Behaviour:
- Reset (async assert, sync-safe deassert upstream): state=OFF, col_en=0, busy=0, on_ack=0, off_ack=0, idx=0, cnt=0. Reset mid-ramp clears every col_en immediately.
- States: OFF, RAMP_UP, ON, RAMP_DOWN. busy is the registered decode of RAMP_UP or RAMP_DOWN.
- OFF:
  - on_req=1 at an edge: latch mask_q=col_mask and step_q=max(step_cyc,1); idx=0, cnt=0; go to RAMP_UP.
  - off_req is ignored in OFF.
  - If on_req and off_req are both high, on_req wins.
- RAMP_UP, each edge:
  - cnt!=0: cnt--.
  - cnt==0 and mask_q[idx]=1: set col_en[idx]=1, cnt=step_q-1.
  - cnt==0 and mask_q[idx]=0: skip the column. A skip costs exactly 1 cycle and leaves cnt=0.
  - After idx==NCOL-1 is processed: go to ON, on_ack=1 for one cycle. Otherwise idx++.
- ON: on_req is ignored. off_req=1 at an edge: idx=NCOL-1, cnt=0, go to RAMP_DOWN.
- RAMP_UP abort: off_req=1 at any edge in RAMP_UP overrides ramp progress. Go to RAMP_DOWN with idx=NCOL-1, cnt=0, and no on_ack. Columns enabled so far stay enabled until ramp-down reaches them.
- RAMP_DOWN, each edge, mirroring ramp-up in descending idx:
  - cnt!=0: cnt--.
  - cnt==0 and col_en[idx]=1: clear it, cnt=step_q-1.
  - cnt==0 and col_en[idx]=0: skip, 1 cycle.
  - After idx==0 is processed: go to OFF, off_ack=1 for one cycle.
  - on_req is ignored; ramp-down always completes.
- col_mask and step_cyc changes outside OFF have no effect.
- Requests are levels. A request held after its ack is harmless (ignored in the target state). A request held through the opposite ramp is honoured once the FSM reaches the state that accepts it.
- All-zero mask: ramp-up walks NCOL skip cycles, then on_ack with col_en=0.
- col_en changes only at clk edges, at most one bit per edge. The downstream latch-based gater provides glitch-free gating.
- NCOL=1: idx is constant 0; single-step ramps.

Test Plan:
1. Reset, NCOL=4, mask=4'b1111, step=4, on_req at edge E0 -> col_en bits 0,1,2,3 rise at E1,E5,E9,E13; on_ack high only in cycle E13–E14; busy high E1–E13.
2. From ON, off_req at E0, step latched=4 -> col_en[3..0] fall at E1,E5,E9,E13; off_ack one cycle at E13; col_en=0.
3. mask=4'b1011, step=4, on_req -> col0@E1, col1@E5, idx2 skip at E9, col3@E10; final col_en=4'b1011; on_ack at E10.
4. step_cyc=0, mask=4'b1111 -> one column per cycle, col_en=4'b1111 at E4, on_ack at E4; then change step_cyc=7 while in ON -> the following ramp-down still uses interval 1.
5. off_req asserted at E6 of case-1 ramp-up (col_en=4'b0011) -> no on_ack; idx3/idx2 skipped at E7,E8; col1 clears at E9; col0 clears at E13; off_ack at E13.
6. Assert rst mid ramp-up with col_en=4'b0111 -> col_en=0, busy=0 without waiting for a clk edge. Both on_req and off_req high in OFF -> RAMP_UP entered, col0 rises.
